// File: rtl/frac_swallow_div_if.sv
// Connection bundle for the fractional-N pulse-swallow divider: run enable,
// divide words and the divided-clock / strobe outputs.
interface frac_swallow_div_if #(
    parameter int P_WIDTH = 5,
    parameter int S_WIDTH = 3,
    parameter int F_WIDTH = 8
) ();
    logic               en;
    logic [P_WIDTH-1:0] Pi;
    logic [S_WIDTH-1:0] Si;
    logic [F_WIDTH-1:0] Fi;
    logic               Fdiv;
    logic               div_pulse;
    logic               cfg_err;

    modport master (
        output en, Pi, Si, Fi,
        input  Fdiv, div_pulse, cfg_err
    );

    modport slave (
        input  en, Pi, Si, Fi,
        output Fdiv, div_pulse, cfg_err
    );
endinterface

// File: rtl/frac_swallow_div.sv
// Fractional-N pulse-swallow divider: N = Ps*MOD_M + Seff, where Seff = S plus
// the carry of a first-order accumulator. The config is resampled at every period boundary.
module frac_swallow_div #(
    parameter int P_WIDTH = 5,
    parameter int S_WIDTH = 3,
    parameter int F_WIDTH = 8,
    parameter int MOD_M   = 8
) (
    input  logic               clk,
    input  logic               rst,
    frac_swallow_div_if.slave  bus
);
    localparam int M_W  = $clog2(MOD_M + 1);
    localparam int SE_W = S_WIDTH + 1;
    localparam int N_W  = P_WIDTH + M_W + 1;
    localparam int C_W  = (P_WIDTH > S_WIDTH) ? P_WIDTH : S_WIDTH;
    localparam logic [M_W-1:0] PRE_LONG  = M_W'(MOD_M);
    localparam logic [M_W-1:0] PRE_SHORT = M_W'(MOD_M - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_reg;
    logic [F_WIDTH-1:0]  acc_reg, acc_next, acc_sum;
    logic [P_WIDTH-1:0]  ps_reg, p_use, p_cnt_reg, p_cnt_next;
    logic [SE_W-1:0]     seff_reg, seff_next, s_cnt_reg, s_cnt_next;
    logic [M_W-1:0]      pre_cnt_reg, pre_cnt_next;
    logic [N_W-1:0]      hi_cnt_reg, hi_cnt_next, n_new, hi_new;
    logic                fdiv_reg, fdiv_next;
    logic                div_pulse_reg, div_pulse_next;
    logic                cfg_err_reg;
    logic                cfg_ok, sample, carry;

    assign cfg_ok = (bus.Pi != '0) && (C_W'(bus.Si) < C_W'(bus.Pi));
    assign sample = bus.en && ((state_reg == IDLE) || div_pulse_reg);
    assign {carry, acc_sum} = {1'b0, acc_reg} + {1'b0, bus.Fi};

    // A rejected word in RUN repeats the previous period exactly (same Ps and
    // same dithered Seff) and leaves the accumulator untouched.
    always_comb begin
        p_use     = cfg_ok ? bus.Pi : ps_reg;
        seff_next = cfg_ok ? (SE_W'(bus.Si) + SE_W'(carry)) : seff_reg;
        acc_next  = cfg_ok ? acc_sum : acc_reg;
        n_new     = N_W'(p_use) * N_W'(MOD_M) + N_W'(seff_next);
        hi_new    = (n_new + N_W'(1)) >> 1;

        pre_cnt_next = pre_cnt_reg;
        p_cnt_next   = p_cnt_reg;
        s_cnt_next   = s_cnt_reg;
        hi_cnt_next  = hi_cnt_reg;
        fdiv_next    = fdiv_reg;

        if (sample) begin
            // s_cnt holds the swallow cycles still owed after the current one.
            pre_cnt_next = (seff_next != '0) ? PRE_LONG : PRE_SHORT;
            p_cnt_next   = p_use - P_WIDTH'(1);
            s_cnt_next   = (seff_next != '0) ? (seff_next - SE_W'(1)) : '0;
            hi_cnt_next  = hi_new - N_W'(1);
            fdiv_next    = 1'b1;
        end else begin
            if (pre_cnt_reg == '0) begin
                p_cnt_next = p_cnt_reg - P_WIDTH'(1);
                if (s_cnt_reg != '0) begin
                    pre_cnt_next = PRE_LONG;
                    s_cnt_next   = s_cnt_reg - SE_W'(1);
                end else begin
                    pre_cnt_next = PRE_SHORT;
                end
            end else begin
                pre_cnt_next = pre_cnt_reg - M_W'(1);
            end
            fdiv_next   = (hi_cnt_reg != '0);
            hi_cnt_next = (hi_cnt_reg != '0) ? (hi_cnt_reg - N_W'(1)) : '0;
        end

        div_pulse_next = (pre_cnt_next == '0) && (p_cnt_next == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            ps_reg        <= '0;
            seff_reg      <= '0;
            pre_cnt_reg   <= '0;
            p_cnt_reg     <= '0;
            s_cnt_reg     <= '0;
            hi_cnt_reg    <= '0;
            fdiv_reg      <= 1'b0;
            div_pulse_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else if (!bus.en) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            ps_reg        <= '0;
            seff_reg      <= '0;
            pre_cnt_reg   <= '0;
            p_cnt_reg     <= '0;
            s_cnt_reg     <= '0;
            hi_cnt_reg    <= '0;
            fdiv_reg      <= 1'b0;
            div_pulse_reg <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else if ((state_reg == IDLE) && !cfg_ok) begin
            cfg_err_reg <= 1'b1;
        end else begin
            state_reg     <= RUN;
            cfg_err_reg   <= sample && !cfg_ok;
            if (sample) begin
                acc_reg  <= acc_next;
                ps_reg   <= p_use;
                seff_reg <= seff_next;
            end
            pre_cnt_reg   <= pre_cnt_next;
            p_cnt_reg     <= p_cnt_next;
            s_cnt_reg     <= s_cnt_next;
            hi_cnt_reg    <= hi_cnt_next;
            fdiv_reg      <= fdiv_next;
            div_pulse_reg <= div_pulse_next;
        end
    end

    assign bus.Fdiv      = fdiv_reg;
    assign bus.div_pulse = div_pulse_reg;
    assign bus.cfg_err   = cfg_err_reg;
endmodule

// File: tb/tb_frac_swallow_div.sv
// Directed bench for frac_swallow_div (MOD_M=8, F_WIDTH=8): period lengths,
// Fdiv duty, config rejection, mid-period reconfiguration, reset and enable drop.
module tb_frac_swallow_div;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    frac_swallow_div_if #(.P_WIDTH(5), .S_WIDTH(3), .F_WIDTH(8)) bus ();

    frac_swallow_div #(.P_WIDTH(5), .S_WIDTH(3), .F_WIDTH(8), .MOD_M(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]      pi;
        logic [2:0]      si;
        logic [7:0]      fi;
        logic [3:0][8:0] len;
        logic [3:0][8:0] hi;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int pi, input int si, input int fi,
                           input int l0, input int l1, input int l2, input int l3,
                           input int h0, input int h1, input int h2, input int h3);
        vt[idx].pi     = 5'(pi);
        vt[idx].si     = 3'(si);
        vt[idx].fi     = 8'(fi);
        vt[idx].len[0] = 9'(l0);
        vt[idx].len[1] = 9'(l1);
        vt[idx].len[2] = 9'(l2);
        vt[idx].len[3] = 9'(l3);
        vt[idx].hi[0]  = 9'(h0);
        vt[idx].hi[1]  = 9'(h1);
        vt[idx].hi[2]  = 9'(h2);
        vt[idx].hi[3]  = 9'(h3);
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        bus.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_cfg(input int pi, input int si, input int fi);
        bus.Pi = 5'(pi);
        bus.Si = 3'(si);
        bus.Fi = 8'(fi);
    endtask

    // Called just after a negedge; the next posedge is the sample edge of the
    // period being measured. Optionally rewrites Pi/Si after chg_at cycles.
    task automatic run_period(input int chg_at, input int chg_p, input int chg_s,
                              output int len, output int hi, output int ce);
        len = 0;
        hi  = 0;
        ce  = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            @(negedge clk);
            len++;
            if (bus.Fdiv)    hi++;
            if (bus.cfg_err) ce++;
            if (chg_at != 0 && len == chg_at) begin
                bus.Pi = 5'(chg_p);
                bus.Si = 3'(chg_s);
            end
            if (bus.div_pulse) begin
                $display("period: Pi=%0d Si=%0d Fi=%0d len=%0d high=%0d cfg_err=%0d",
                         bus.Pi, bus.Si, bus.Fi, len, hi, ce);
                return;
            end
        end
        len = -1;
        $display("period: no div_pulse within 600 cycles");
    endtask

    task automatic expect_frac64(input string tag);
        int len, hi, ce;
        for (int j = 0; j < 4; j++) begin
            run_period(0, 0, 0, len, hi, ce);
            check($sformatf("%s_len%0d", tag, j), len, (j == 3) ? 133 : 132);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, hi, ce, cnt_ce, cnt_dp, cnt_fd;
        set_cfg(0, 0, 0);
        bus.en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("reset_fdiv", int'(bus.Fdiv), 0);
        check("reset_div_pulse", int'(bus.div_pulse), 0);
        check("reset_cfg_err", int'(bus.cfg_err), 0);

        set_vec(0, 16, 4, 0,   132, 132, 132, 132,  66, 66, 66, 66);
        set_vec(1, 16, 4, 64,  132, 132, 132, 133,  66, 66, 66, 67);
        set_vec(2, 2, 1, 0,    17, 17, 17, 17,      9, 9, 9, 9);
        set_vec(3, 1, 0, 0,    8, 8, 8, 8,          4, 4, 4, 4);
        set_vec(4, 31, 7, 255, 255, 256, 256, 256,  128, 128, 128, 128);
        set_vec(5, 3, 2, 128,  26, 27, 26, 27,      13, 14, 13, 14);

        for (int v = 0; v < 6; v++) begin
            int ce_sum;
            do_reset();
            set_cfg(int'(vt[v].pi), int'(vt[v].si), int'(vt[v].fi));
            bus.en = 1'b1;
            ce_sum = 0;
            for (int j = 0; j < 4; j++) begin
                run_period(0, 0, 0, len, hi, ce);
                ce_sum += ce;
                check($sformatf("vec%0d_len%0d", v, j), len, int'(vt[v].len[j]));
                check($sformatf("vec%0d_high%0d", v, j), hi, int'(vt[v].hi[j]));
            end
            check($sformatf("vec%0d_cfg_err", v), ce_sum, 0);
            bus.en = 1'b0;
        end

        // Pi changed mid-period: current period finishes at 132, then N=84.
        do_reset();
        set_cfg(16, 4, 0);
        bus.en = 1'b1;
        run_period(60, 10, 4, len, hi, ce);
        check("midchg_len0", len, 132);
        run_period(0, 0, 0, len, hi, ce);
        check("midchg_len1", len, 84);
        check("midchg_high1", hi, 42);
        run_period(0, 0, 0, len, hi, ce);
        check("midchg_len2", len, 84);

        // Illegal word from IDLE: cfg_err every cycle, no output activity.
        do_reset();
        set_cfg(4, 5, 0);
        bus.en = 1'b1;
        cnt_ce = 0; cnt_dp = 0; cnt_fd = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.cfg_err)   cnt_ce++;
            if (bus.div_pulse) cnt_dp++;
            if (bus.Fdiv)      cnt_fd++;
        end
        check("idle_bad_cfg_err", cnt_ce, 10);
        check("idle_bad_div_pulse", cnt_dp, 0);
        check("idle_bad_fdiv", cnt_fd, 0);

        // Now legal, then illegal while running: N holds, one cfg_err per boundary.
        set_cfg(16, 4, 0);
        run_period(0, 0, 0, len, hi, ce);
        check("run_bad_len0", len, 132);
        check("run_bad_ce0", ce, 0);
        run_period(50, 4, 5, len, hi, ce);
        check("run_bad_len1", len, 132);
        check("run_bad_ce1", ce, 0);
        run_period(0, 0, 0, len, hi, ce);
        check("run_bad_len2", len, 132);
        check("run_bad_ce2", ce, 1);
        run_period(0, 0, 0, len, hi, ce);
        check("run_bad_len3", len, 132);
        check("run_bad_ce3", ce, 1);

        // Asynchronous reset mid-period clears outputs at once and the accumulator.
        do_reset();
        set_cfg(16, 4, 64);
        bus.en = 1'b1;
        run_period(0, 0, 0, len, hi, ce);
        run_period(0, 0, 0, len, hi, ce);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_fdiv", int'(bus.Fdiv), 1);
        rst = 1'b1;
        #1;
        check("rst_fdiv", int'(bus.Fdiv), 0);
        check("rst_div_pulse", int'(bus.div_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        expect_frac64("after_rst");

        // Enable dropped mid-period: IDLE on next edge, accumulator restarts.
        do_reset();
        set_cfg(16, 4, 64);
        bus.en = 1'b1;
        run_period(0, 0, 0, len, hi, ce);
        run_period(0, 0, 0, len, hi, ce);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_en_fdiv", int'(bus.Fdiv), 1);
        bus.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en_low_fdiv", int'(bus.Fdiv), 0);
        check("en_low_div_pulse", int'(bus.div_pulse), 0);
        cnt_dp = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.div_pulse || bus.Fdiv) cnt_dp++;
        end
        check("en_low_idle_activity", cnt_dp, 0);
        bus.en = 1'b1;
        expect_frac64("reenable");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
